// File: rtl/rx_sequences_correlator.sv
// Correlates a 255-sample circular history against 16 PRBS chip streams, one chip per two clocks.
// Optional sticky abort flag built only when RX_CORR_OVERRUN_EN is defined.
module rx_sequences_correlator #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SEQ_LEN  = 255,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                  crx_clk,
  input  logic                  rrx_rst_n,
  input  logic                  erx_en,
  input  logic                  inew_sample_trig,
  input  logic [SAMPLE_W-1:0]   isample,
  input  logic [15:0]           isequences_bits,
  output logic [16*ACC_W-1:0]   ocorr,
  output logic                  ocorr_valid,
  output logic                  obusy,
  output logic                  ooverrun
);

  localparam int unsigned PtrW = $clog2(SEQ_LEN);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(SEQ_LEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  phase_q;
  logic [PtrW-1:0]       chip_q;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_nxt;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_nxt;
  logic [SAMPLE_W-1:0]   mem_q [SEQ_LEN];
  logic [ACC_W-1:0]      acc_q [16];
  logic [16*ACC_W-1:0]   acc_flat;
  logic [16*ACC_W-1:0]   ocorr_q;
  logic                  valid_q;

  logic                  trig;
  logic                  add_chip;
  logic                  last_chip;
  logic [SAMPLE_W-1:0]   rd_sample;
  logic [ACC_W-1:0]      term_pos, term_neg;

  assign trig      = erx_en & inew_sample_trig;
  assign add_chip  = erx_en & (state_q == StRun) & phase_q;
  assign last_chip = (chip_q == PtrLast);

  assign wr_ptr_nxt = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
  assign rd_ptr_nxt = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);

  // Sign-extend before negating so the most negative sample negates exactly.
  assign rd_sample = mem_q[rd_ptr_q];
  assign term_pos  = {{(ACC_W - SAMPLE_W){rd_sample[SAMPLE_W-1]}}, rd_sample};
  assign term_neg  = -term_pos;

  always_comb begin
    state_d = state_q;
    if (!erx_en) begin
      state_d = StIdle;
    end else if (inew_sample_trig) begin
      state_d = StRun;
    end else begin
      case (state_q)
        StRun:   if (phase_q && last_chip) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      state_q  <= StIdle;
      phase_q  <= 1'b0;
      chip_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (trig) begin
        // Chip 0 pairs with the oldest entry, which sits at the advanced write pointer.
        phase_q  <= 1'b0;
        chip_q   <= '0;
        wr_ptr_q <= wr_ptr_nxt;
        rd_ptr_q <= wr_ptr_nxt;
      end else if (erx_en && (state_q == StRun)) begin
        phase_q <= ~phase_q;
        if (phase_q) begin
          chip_q   <= chip_q + PtrW'(1);
          rd_ptr_q <= rd_ptr_nxt;
        end
      end
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      for (int i = 0; i < int'(SEQ_LEN); i++) begin
        mem_q[i] <= '0;
      end
    end else if (trig) begin
      mem_q[wr_ptr_q] <= isample;
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      for (int j = 0; j < 16; j++) begin
        acc_q[j] <= '0;
      end
    end else if (trig) begin
      for (int j = 0; j < 16; j++) begin
        acc_q[j] <= '0;
      end
    end else if (add_chip) begin
      for (int j = 0; j < 16; j++) begin
        acc_q[j] <= acc_q[j] + (isequences_bits[j] ? term_pos : term_neg);
      end
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int j = 0; j < 16; j++) begin
      acc_flat[j*ACC_W +: ACC_W] = acc_q[j];
    end
  end

  // A trigger landing in the DONE cycle still lets the finished run publish.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      ocorr_q <= '0;
      valid_q <= 1'b0;
    end else if (erx_en && (state_q == StDone)) begin
      ocorr_q <= acc_flat;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign ocorr       = ocorr_q;
  assign ocorr_valid = valid_q;
  assign obusy       = (state_q == StRun);

`ifdef RX_CORR_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      overrun_q <= 1'b0;
    end else if (trig && (state_q == StRun)) begin
      overrun_q <= 1'b1;
    end
  end

  assign ooverrun = overrun_q;
`else
  assign ooverrun = 1'b0;
`endif

endmodule

// File: tb/tb_rx_sequences_correlator.sv
// Self-checking bench: acts as the chip feeder, models the history and scoreboards every result.
module tb_rx_sequences_correlator;

  localparam int SW  = 16;
  localparam int SL  = 255;
  localparam int AW  = 24;
  localparam int LAT = 511;

`ifdef RX_CORR_OVERRUN_EN
  localparam int OvrExp = 1;
`else
  localparam int OvrExp = 0;
`endif

  logic              crx_clk = 1'b0;
  logic              rrx_rst_n = 1'b0;
  logic              erx_en = 1'b0;
  logic              inew_sample_trig = 1'b0;
  logic [SW-1:0]     isample = '0;
  logic [15:0]       isequences_bits = '0;
  logic [16*AW-1:0]  ocorr;
  logic              ocorr_valid;
  logic              obusy;
  logic              ooverrun;

  always #5 crx_clk = ~crx_clk;

  rx_sequences_correlator #(
    .SAMPLE_W(SW),
    .SEQ_LEN (SL),
    .ACC_W   (AW)
  ) dut (
    .crx_clk         (crx_clk),
    .rrx_rst_n       (rrx_rst_n),
    .erx_en          (erx_en),
    .inew_sample_trig(inew_sample_trig),
    .isample         (isample),
    .isequences_bits (isequences_bits),
    .ocorr           (ocorr),
    .ocorr_valid     (ocorr_valid),
    .obusy           (obusy),
    .ooverrun        (ooverrun)
  );

  int checks = 0;
  int passes = 0;
  int valid_cnt = 0;
  logic [16*AW-1:0] last_ocorr = '0;

  // Reference model state
  int               hist [SL];
  int               mwr = 0;
  logic             pend = 1'b0;
  int               age = 0;
  logic [16*AW-1:0] pend_sums = '0;
  logic [16*AW-1:0] sb_q [$];
  int               feed = 0;
  int               mode = 0;
  logic             en_r = 1'b0;

  typedef struct {
    int sample;
    int mode;
    int exp0;
    int exp15;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passes++;
  endtask

  function automatic int seqsum(input logic [16*AW-1:0] v, input int j);
    logic signed [AW-1:0] t;
    t = v[j*AW +: AW];
    return int'(t);
  endfunction

  function automatic logic prnd(input int k, input int j);
    int h;
    h = k * 131 + j * 977 + k * j * 29;
    h = h ^ (h >> 3);
    return h[2];
  endfunction

  // Mode 0: all ones. Mode 1: seq0 alternates 0/1 from chip 0, seq15 all zero. Mode 2: pseudo-random.
  function automatic logic [15:0] pat(input int m, input int k);
    logic [15:0] b;
    for (int j = 0; j < 16; j++) begin
      if (m == 0) b[j] = 1'b1;
      else if (m == 1 && j == 0) b[j] = k[0];
      else if (m == 1 && j == 15) b[j] = 1'b0;
      else b[j] = prnd(k, j);
    end
    return b;
  endfunction

  task automatic compute_expected();
    int sums [16];
    logic [15:0] b;
    for (int j = 0; j < 16; j++) sums[j] = 0;
    for (int k = 0; k < SL; k++) begin
      b = pat(mode, k);
      for (int j = 0; j < 16; j++) begin
        if (b[j]) sums[j] += hist[(mwr + k) % SL];
        else sums[j] -= hist[(mwr + k) % SL];
      end
    end
    for (int j = 0; j < 16; j++) pend_sums[j*AW +: AW] = AW'(sums[j]);
  endtask

  task automatic model_edge(input logic acc, input logic [SW-1:0] samp);
    logic signed [SW-1:0] s;
    if (pend) begin
      age++;
      if (!en_r) pend = 1'b0;
      else if (age == LAT) begin
        sb_q.push_back(pend_sums);
        pend = 1'b0;
      end
    end
    if (acc) begin
      s = samp;
      hist[mwr] = int'(s);
      mwr = (mwr + 1) % SL;
      compute_expected();
      pend = 1'b1;
      age = 0;
      feed = 1;
    end else if (feed > 0) begin
      feed++;
    end
  endtask

  task automatic monitor();
    logic exp_v;
    logic [16*AW-1:0] e;
    exp_v = (sb_q.size() > 0);
    if (exp_v || ocorr_valid) check("valid_pulse", int'(ocorr_valid), int'(exp_v));
    if (ocorr_valid) begin
      valid_cnt++;
      last_ocorr = ocorr;
    end
    if (exp_v) begin
      e = sb_q.pop_front();
      if (ocorr_valid) begin
        for (int j = 0; j < 16; j++) check($sformatf("sum_seq%0d", j), seqsum(ocorr, j), seqsum(e, j));
      end
    end
  endtask

  task automatic step(input logic trig, input logic [SW-1:0] samp);
    inew_sample_trig = trig;
    isample = samp;
    erx_en = en_r;
    @(posedge crx_clk);
    model_edge(trig && en_r && rrx_rst_n, samp);
    #1;
    isequences_bits = (feed >= 1 && feed <= 2 * SL) ? pat(mode, (feed - 1) / 2) : 16'h0;
    @(negedge crx_clk);
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{sample: 1,      mode: 0, exp0: 255,     exp15: 255};
    vecs[1] = '{sample: -32768, mode: 1, exp0: 32768,   exp15: 8355840};
    vecs[2] = '{sample: 32767,  mode: 0, exp0: 8355585, exp15: 8355585};
    vecs[3] = '{sample: -1,     mode: 1, exp0: 1,       exp15: 255};
    for (int i = 0; i < SL; i++) hist[i] = 0;

    repeat (3) @(negedge crx_clk);
    check("reset_ocorr_zero", int'(ocorr == '0), 1);
    check("reset_obusy", int'(obusy), 0);
    check("reset_valid", int'(ocorr_valid), 0);
    check("reset_overrun", int'(ooverrun), 0);
    rrx_rst_n = 1'b1;
    en_r = 1'b1;

    // Quiet after reset
    idle(1000);
    check("quiet_valid_count", valid_cnt, 0);
    check("quiet_ocorr_zero", int'(ocorr == '0), 1);
    check("quiet_obusy", int'(obusy), 0);
    check("quiet_overrun", int'(ooverrun), 0);

    // Table: fill the whole history with one value, then check hand-derived sums
    for (int r = 0; r < 4; r++) begin
      mode = vecs[r].mode;
      valid_cnt = 0;
      for (int i = 0; i < SL; i++) begin
        step(1'b1, SW'(vecs[r].sample));
        step(1'b0, '0);
      end
      idle(520);
      check($sformatf("vec%0d_valid_count", r), valid_cnt, 1);
      check($sformatf("vec%0d_seq0", r), seqsum(last_ocorr, 0), vecs[r].exp0);
      check($sformatf("vec%0d_seq15", r), seqsum(last_ocorr, 15), vecs[r].exp15);
    end

    // Abort: second trigger at cycle 300
    mode = 2;
    valid_cnt = 0;
    step(1'b1, SW'(500));
    idle(299);
    step(1'b1, SW'(-600));
    idle(520);
    check("abort_valid_count", valid_cnt, 1);
    check("abort_overrun", int'(ooverrun), OvrExp);

    // Enable dropped at cycle 100 for 50 cycles, with triggers ignored meanwhile
    valid_cnt = 0;
    step(1'b1, SW'(777));
    idle(99);
    en_r = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, SW'(12345));
      step(1'b0, '0);
    end
    check("en_low_obusy", int'(obusy), 0);
    en_r = 1'b1;
    idle(600);
    check("en_low_valid_count", valid_cnt, 0);
    step(1'b1, SW'(-4321));
    idle(520);
    check("en_after_valid_count", valid_cnt, 1);

    // 300 triggers wrap the write pointer; final run checked against the model
    valid_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, SW'($urandom));
      step(1'b0, '0);
    end
    idle(520);
    check("wrap_valid_count", valid_cnt, 1);

    // Asynchronous reset mid-run
    valid_cnt = 0;
    step(1'b1, SW'(999));
    idle(200);
    #2;
    rrx_rst_n = 1'b0;
    #1;
    check("midrst_obusy", int'(obusy), 0);
    check("midrst_ocorr_zero", int'(ocorr == '0), 1);
    check("midrst_overrun", int'(ooverrun), 0);
    check("midrst_valid", int'(ocorr_valid), 0);
    for (int i = 0; i < SL; i++) hist[i] = 0;
    mwr = 0;
    pend = 1'b0;
    feed = 0;
    sb_q.delete();
    @(negedge crx_clk);
    @(negedge crx_clk);
    rrx_rst_n = 1'b1;
    idle(600);
    check("midrst_valid_count", valid_cnt, 0);

    // Clean run: obusy window, then a trigger in the DONE cycle both publishes and restarts
    valid_cnt = 0;
    step(1'b1, SW'(1000));
    check("busy_cycle1", int'(obusy), 1);
    idle(LAT - 2);
    check("busy_cycle510", int'(obusy), 1);
    idle(1);
    check("busy_cycle511", int'(obusy), 0);
    check("no_valid_before_511", valid_cnt, 0);
    step(1'b1, SW'(-2000));
    check("done_trig_valid_count", valid_cnt, 1);
    check("done_trig_restart_busy", int'(obusy), 1);
    idle(520);
    check("done_trig_total_valid", valid_cnt, 2);
    check("done_trig_overrun", int'(ooverrun), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
